// File: rtl/freq_meas_sequencer.sv
// Measures the period of signal_in in clk cycles and converts it to Hz through a shared divider.
// Latency: frequency/freq_valid 1 cycle after div_done; backpressure: none, divider handshake held until div_done.
module freq_meas_sequencer #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int DIVIDEND_W  = 26,
    parameter int PERIOD_W    = 24,
    parameter int FREQ_W      = 20,
    parameter int TIMEOUT_CYC = 16_777_215,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signal_in,
    input  logic                  enable,
    output logic                  div_start,
    output logic [DIVIDEND_W-1:0] div_dividend,
    output logic [PERIOD_W-1:0]   div_divisor,
    input  logic                  div_done,
    input  logic [DIVIDEND_W-1:0] div_quotient,
    output logic [PERIOD_W-1:0]   period,
    output logic [FREQ_W-1:0]     frequency,
    output logic                  freq_valid,
    output logic                  no_signal
);
    localparam logic [PERIOD_W-1:0]   TIMEOUT_VAL = PERIOD_W'(TIMEOUT_CYC);
    localparam logic [DIVIDEND_W-1:0] FREQ_MAX    = DIVIDEND_W'((64'd1 << FREQ_W) - 64'd1);

    typedef enum logic [2:0] {IDLE, ARM, MEASURE, DIVIDE, UPDATE} state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_d;
    logic                   rise;
    logic [PERIOD_W-1:0]    cnt;
    logic                   abort;
    logic                   timeout;
    logic                   cnt_clr, cnt_set1, cnt_inc;
    logic                   ld_period, ld_freq, ld_to;

    assign div_dividend = DIVIDEND_W'(CLK_HZ);
    assign rise         = sync[SYNC_STAGES-1] & ~sync_d;
    assign timeout      = (cnt == TIMEOUT_VAL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync   <= '0;
            sync_d <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], signal_in};
            sync_d <= sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_set1  = 1'b0;
        cnt_inc   = 1'b0;
        ld_period = 1'b0;
        ld_freq   = 1'b0;
        ld_to     = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                if (enable) state_nxt = ARM;
            end
            ARM: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (rise) begin
                    cnt_set1  = 1'b1;
                    state_nxt = MEASURE;
                end else if (timeout) begin
                    ld_to   = 1'b1;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            MEASURE: begin
                // A rise coinciding with the timeout still yields a valid period.
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (rise) begin
                    ld_period = 1'b1;
                    state_nxt = DIVIDE;
                end else if (timeout) begin
                    ld_to     = 1'b1;
                    cnt_clr   = 1'b1;
                    state_nxt = ARM;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            DIVIDE: begin
                if (div_done) begin
                    if (abort || !enable) begin
                        state_nxt = IDLE;
                    end else begin
                        ld_freq   = 1'b1;
                        state_nxt = UPDATE;
                    end
                end
            end
            UPDATE: begin
                cnt_clr   = 1'b1;
                state_nxt = enable ? ARM : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            abort       <= 1'b0;
            div_start   <= 1'b0;
            div_divisor <= '0;
            period      <= '0;
            frequency   <= '0;
            freq_valid  <= 1'b0;
            no_signal   <= 1'b1;
        end else begin
            div_start  <= ld_period;
            freq_valid <= ld_freq | ld_to;
            // Once enable drops mid-divide the pending quotient is discarded even if enable returns.
            abort      <= (state == DIVIDE) ? (abort | ~enable) : 1'b0;
            if (cnt_clr)       cnt <= '0;
            else if (cnt_set1) cnt <= PERIOD_W'(1);
            else if (cnt_inc)  cnt <= cnt + PERIOD_W'(1);
            if (ld_period) begin
                div_divisor <= cnt;
                period      <= cnt;
            end
            if (ld_freq) begin
                frequency <= (div_quotient > FREQ_MAX) ? '1 : div_quotient[FREQ_W-1:0];
                no_signal <= 1'b0;
            end else if (ld_to) begin
                frequency <= '0;
                no_signal <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_freq_meas_sequencer.sv
// Self-checking bench for freq_meas_sequencer with a behavioural divider and signal generator.
module tb_freq_meas_sequencer;
    localparam int CLK_HZ = 50_000_000;
    localparam int DW     = 26;
    localparam int PW     = 24;
    localparam int FW     = 20;
    localparam int TO     = 5000;
    localparam int FMAX   = (1 << FW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          signal_in;
    logic          enable;
    logic          div_start;
    logic [DW-1:0] div_dividend;
    logic [PW-1:0] div_divisor;
    logic          div_done;
    logic [DW-1:0] div_quotient;
    logic [PW-1:0] period;
    logic [FW-1:0] frequency;
    logic          freq_valid;
    logic          no_signal;

    freq_meas_sequencer #(
        .CLK_HZ(CLK_HZ), .DIVIDEND_W(DW), .PERIOD_W(PW), .FREQ_W(FW),
        .TIMEOUT_CYC(TO), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .rst(rst), .signal_in(signal_in), .enable(enable),
        .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_done(div_done), .div_quotient(div_quotient), .period(period),
        .frequency(frequency), .freq_valid(freq_valid), .no_signal(no_signal)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int ncyc   = 0;
    always @(posedge clk) ncyc <= ncyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic chk_rng(input string name, input longint act, input longint lo, input longint hi);
        checks++;
        if (act >= lo && act <= hi) passed++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    endtask

    function automatic int exp_freq(input int p);
        int q;
        q = CLK_HZ / p;
        return (q > FMAX) ? FMAX : q;
    endfunction

    // Behavioural divider: answers 1..40 cycles after each start.
    int            start_cnt = 0;
    int            fixed_dly = 0;
    int            busy_rem  = 0;
    int            stab_err  = 0;
    int            done_cyc  = 0;
    int            last_div  = 0;
    bit            busy      = 0;
    logic [PW-1:0] cap_div;
    initial begin
        div_done     = 1'b0;
        div_quotient = '0;
        cap_div      = '0;
        forever begin
            @(negedge clk);
            div_done = 1'b0;
            if (rst) begin
                busy = 0;
            end else begin
                if (busy) begin
                    if (div_divisor != cap_div) stab_err++;
                    busy_rem--;
                    if (busy_rem == 0) begin
                        div_done     = 1'b1;
                        div_quotient = DW'(CLK_HZ / int'(cap_div));
                        busy         = 0;
                        done_cyc     = ncyc;
                    end
                end
                if (div_start) begin
                    start_cnt++;
                    cap_div  = div_divisor;
                    last_div = int'(div_divisor);
                    busy     = 1;
                    busy_rem = (fixed_dly != 0) ? fixed_dly : int'($urandom_range(1, 40));
                end
            end
        end
    end

    // Square-wave generator: rising edges exactly gen_p cycles apart; gen_p=0 holds low.
    int gen_p       = 0;
    int gen_cnt     = 0;
    int gen_rises   = 0;
    bit gen_restart = 0;
    initial begin
        signal_in = 1'b0;
        forever begin
            @(negedge clk);
            if (gen_restart) begin
                gen_restart = 0;
                gen_cnt     = gen_p / 2;
                signal_in   = 1'b0;
            end else if (gen_p == 0) begin
                signal_in = 1'b0;
            end else begin
                gen_cnt = (gen_cnt + 1) % gen_p;
                if (gen_cnt < gen_p / 2 && !signal_in) gen_rises++;
                signal_in = (gen_cnt < gen_p / 2);
            end
        end
    end

    task automatic wait_fv(input int budget, input string tag);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (freq_valid) begin
                ok = 1;
                break;
            end
        end
        chk({tag, "_valid_seen"}, ok, 1);
    endtask

    int last_p = 0;

    task automatic run_vec(input int p, input int expf, input int dly, input string tag);
        int s0;
        enable = 1'b0;
        repeat (60) @(negedge clk);
        fixed_dly   = dly;
        gen_p       = p;
        gen_restart = 1;
        s0          = start_cnt;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        wait_fv(4 * p + 300, tag);
        chk({tag, "_freq"}, frequency, expf);
        chk({tag, "_period"}, period, p);
        chk({tag, "_no_signal"}, no_signal, 0);
        chk({tag, "_starts"}, start_cnt - s0, 1);
        chk({tag, "_divisor"}, last_div, p);
        chk({tag, "_latency"}, ncyc - done_cyc, 1);
        @(negedge clk);
        chk({tag, "_pulse_len"}, freq_valid, 0);
        last_p = p;
    endtask

    typedef struct {
        int p;
        int freq;
        int dly;
    } vec_t;
    vec_t vecs[7];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, t0, t1, r0, fv_cnt;
        bit ok;
        vecs[0] = '{1000, 50000, 0};
        vecs[1] = '{2, 1048575, 0};
        vecs[2] = '{250, 200000, 7};
        vecs[3] = '{47, 1048575, 1};
        vecs[4] = '{48, 1041666, 40};
        vecs[5] = '{4096, 12207, 0};
        vecs[6] = '{3, 1048575, 0};

        rst    = 1'b1;
        enable = 1'b0;
        #3;
        chk("rst_frequency", frequency, 0);
        chk("rst_period", period, 0);
        chk("rst_freq_valid", freq_valid, 0);
        chk("rst_no_signal", no_signal, 1);
        chk("rst_div_start", div_start, 0);
        chk("rst_div_divisor", div_divisor, 0);
        chk("div_dividend", div_dividend, CLK_HZ);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i])
            run_vec(vecs[i].p, vecs[i].freq, vecs[i].dly, $sformatf("tbl%0d_p%0d", i, vecs[i].p));

        for (int i = 0; i < 10; i++) begin
            int p;
            p = int'($urandom_range(2, 600));
            run_vec(p, exp_freq(p), 0, $sformatf("rnd%0d_p%0d", i, p));
        end

        // Loss of signal: repeated timeouts with no divider activity.
        enable = 1'b0;
        repeat (60) @(negedge clk);
        gen_p       = 0;
        gen_restart = 1;
        s0          = start_cnt;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        t0     = ncyc;
        wait_fv(TO + 100, "to1");
        chk_rng("to1_elapsed", ncyc - t0, TO, TO + 10);
        chk("to1_freq", frequency, 0);
        chk("to1_no_signal", no_signal, 1);
        chk("to1_period_held", period, last_p);
        t1 = ncyc;
        @(negedge clk);
        chk("to1_pulse_len", freq_valid, 0);
        wait_fv(TO + 100, "to2");
        chk_rng("to2_interval", ncyc - t1, TO - 1, TO + 2);
        chk("to2_no_signal", no_signal, 1);
        chk("to_no_starts", start_cnt - s0, 0);

        // Enable dropped while the divider is busy.
        enable = 1'b0;
        repeat (60) @(negedge clk);
        fixed_dly   = 40;
        gen_p       = 1000;
        gen_restart = 1;
        s0          = start_cnt;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        ok     = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (start_cnt != s0) begin
                ok = 1;
                break;
            end
        end
        chk("abort_start_seen", ok, 1);
        enable = 1'b0;
        t0     = done_cyc;
        fv_cnt = 0;
        ok     = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (freq_valid) fv_cnt++;
            if (done_cyc != t0) begin
                ok = 1;
                break;
            end
        end
        chk("abort_done_seen", ok, 1);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (freq_valid) fv_cnt++;
        end
        chk("abort_no_valid", fv_cnt, 0);
        chk("abort_starts", start_cnt - s0, 1);
        chk("abort_freq_held", frequency, 0);
        chk("abort_no_signal_held", no_signal, 1);
        chk("abort_period", period, 1000);
        fixed_dly = 0;

        // Period change 1000 -> 250 with enable held.
        repeat (10) @(negedge clk);
        gen_p       = 1000;
        gen_restart = 1;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        wait_fv(4300, "chg1");
        chk("chg1_freq", frequency, exp_freq(1000));
        @(negedge clk);
        chk("chg1_pulse_len", freq_valid, 0);
        gen_p       = 250;
        gen_restart = 1;
        wait_fv(1500, "chg2");
        chk("chg2_freq", frequency, exp_freq(250));
        chk("chg2_period", period, 250);
        @(negedge clk);
        chk("chg2_pulse_len", freq_valid, 0);

        // Asynchronous reset in the middle of a measurement.
        r0 = gen_rises;
        for (int i = 0; i < 600 && gen_rises == r0; i++) @(negedge clk);
        chk("mrst_rise_seen", gen_rises != r0, 1);
        repeat (30) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_frequency", frequency, 0);
        chk("mrst_period", period, 0);
        chk("mrst_no_signal", no_signal, 1);
        chk("mrst_freq_valid", freq_valid, 0);
        chk("mrst_div_start", div_start, 0);
        chk("mrst_div_divisor", div_divisor, 0);
        for (int i = 0; i < 600 && !signal_in; i++) @(negedge clk);
        for (int i = 0; i < 600 && signal_in; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        r0  = gen_rises;
        wait_fv(1500, "mrst");
        chk_rng("mrst_rises_needed", gen_rises - r0, 2, 100);
        chk("mrst_freq", frequency, exp_freq(250));
        chk("mrst_period_after", period, 250);

        chk("divisor_stable", stab_err, 0);

        enable = 1'b0;
        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
